// File: rtl/axi4_aw_grant_router.sv
// Registers the granted master's AW request onto a shared slave AW channel and
// steers W beats from the master at the head of an in-order routing FIFO.
module axi4_aw_grant_router #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  localparam int MW = $clog2(NUM_MASTERS),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       grant_valid,
  input  logic [MW-1:0]              grant_master,
  output logic                       grant_ready,
  input  logic [ID_WIDTH-1:0]        m_awid    [NUM_MASTERS],
  input  logic [ADDR_WIDTH-1:0]      m_awaddr  [NUM_MASTERS],
  input  logic [7:0]                 m_awlen   [NUM_MASTERS],
  input  logic [2:0]                 m_awsize  [NUM_MASTERS],
  input  logic [1:0]                 m_awburst [NUM_MASTERS],
  input  logic [3:0]                 m_awqos   [NUM_MASTERS],
  output logic                       s_awvalid,
  output logic [ID_WIDTH+MW-1:0]     s_awid,
  output logic [ADDR_WIDTH-1:0]      s_awaddr,
  output logic [7:0]                 s_awlen,
  output logic [2:0]                 s_awsize,
  output logic [1:0]                 s_awburst,
  output logic [3:0]                 s_awqos,
  input  logic                       s_awready,
  input  logic [DATA_WIDTH-1:0]      m_wdata   [NUM_MASTERS],
  input  logic [DATA_WIDTH/8-1:0]    m_wstrb   [NUM_MASTERS],
  input  logic                       m_wlast   [NUM_MASTERS],
  input  logic                       m_wvalid  [NUM_MASTERS],
  output logic                       m_wready  [NUM_MASTERS],
  output logic [DATA_WIDTH-1:0]      s_wdata,
  output logic [DATA_WIDTH/8-1:0]    s_wstrb,
  output logic                       s_wlast,
  output logic                       s_wvalid,
  input  logic                       s_wready,
  output logic [PW:0]                wfifo_count,
  output logic                       w_len_err
);

  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  logic [MW-1:0] fifo_mst [FIFO_DEPTH];
  logic [7:0]    fifo_len [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    beat;
  logic [MW-1:0] head_mst;
  logic [7:0]    head_len;
  logic          fifo_empty, grant_hs, w_hs, pop;

  assign fifo_empty  = (wfifo_count == '0);
  assign grant_ready = (!s_awvalid || s_awready) && (wfifo_count < DEPTH);
  assign grant_hs    = grant_valid && grant_ready;
  assign head_mst    = fifo_mst[rd_ptr];
  assign head_len    = fifo_len[rd_ptr];
  assign w_hs        = s_wvalid && s_wready;
  assign pop         = w_hs && s_wlast;

  // W steering: only the head master sees s_wready; an empty FIFO blocks everyone
  always_comb begin
    s_wdata  = m_wdata[head_mst];
    s_wstrb  = m_wstrb[head_mst];
    s_wlast  = m_wlast[head_mst];
    s_wvalid = !fifo_empty && m_wvalid[head_mst];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_wready[i] = !fifo_empty && (head_mst == MW'(i)) && s_wready;
    end
  end

  // AW output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_awvalid <= 1'b0;
      s_awid    <= '0;
      s_awaddr  <= '0;
      s_awlen   <= '0;
      s_awsize  <= '0;
      s_awburst <= '0;
      s_awqos   <= '0;
    end else if (grant_hs) begin
      s_awvalid <= 1'b1;
      s_awid    <= {grant_master, m_awid[grant_master]};
      s_awaddr  <= m_awaddr[grant_master];
      s_awlen   <= m_awlen[grant_master];
      s_awsize  <= m_awsize[grant_master];
      s_awburst <= m_awburst[grant_master];
      s_awqos   <= m_awqos[grant_master];
    end else if (s_awready) begin
      s_awvalid <= 1'b0;
    end
  end

  // Routing FIFO storage is data only; validity is carried by the count
  always_ff @(posedge clk) begin
    if (grant_hs) begin
      fifo_mst[wr_ptr] <= grant_master;
      fifo_len[wr_ptr] <= m_awlen[grant_master];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wfifo_count <= '0;
    end else begin
      if (grant_hs) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({grant_hs, pop})
        2'b10:   wfifo_count <= wfifo_count + 1'b1;
        2'b01:   wfifo_count <= wfifo_count - 1'b1;
        default: wfifo_count <= wfifo_count;
      endcase
    end
  end

  // Beat tracking; a missing or early wlast is flagged but the burst still ends on wlast
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      w_len_err <= 1'b0;
    end else if (w_hs) begin
      if (s_wlast != (beat == head_len)) w_len_err <= 1'b1;
      beat <= s_wlast ? 8'd0 : beat + 8'd1;
    end
  end

endmodule
